// File: rtl/drac_pkg.sv
// Shared types for the icache refill path: FSM states, block-address type
// and the default line geometry.
package drac_pkg;

  localparam int DEFAULT_NUM_BEATS = 4;
  localparam int BEAT_W            = 128;
  localparam int CNT_W             = 16;

  typedef logic [25:0] block_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } refill_state_e;

endpackage

// File: rtl/icache_refill_requester.sv
// Issues one acquire per icache miss, collects grant beats in any order into
// a line buffer and hands the completed line back; handles kill and timeout.
module icache_refill_requester
  import drac_pkg::*;
#(
  parameter int NUM_BEATS      = DEFAULT_NUM_BEATS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          miss_valid_i,
  input  logic [25:0]                   miss_paddr_i,
  output logic                          miss_ready_o,
  input  logic                          kill_i,
  output logic                          acquire_valid_o,
  output logic [25:0]                   acquire_addr_block_o,
  input  logic                          grant_valid_i,
  input  logic [127:0]                  grant_data_i,
  input  logic [1:0]                    grant_beat_i,
  output logic                          line_valid_o,
  output logic [BEAT_W*NUM_BEATS-1:0]   line_data_o,
  output logic [25:0]                   line_paddr_o,
  output logic                          timeout_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  refill_state_e                 state_q, state_d;
  block_addr_t                   addr_q, addr_d;
  logic [NUM_BEATS-1:0]          mask_q, mask_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BEAT_W*NUM_BEATS-1:0]   line_q;
  block_addr_t                   line_paddr_q;

  logic                          in_collect, beat_hit, timeout_hit, full, line_load;
  logic [NUM_BEATS-1:0]          beat_onehot, mask_upd;
  logic [BEAT_W*NUM_BEATS-1:0]   merged;

  assign in_collect  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign beat_hit    = in_collect && grant_valid_i;
  assign timeout_hit = in_collect && (cnt_q == TO_LAST);

  // merged is the buffer as it will look after this cycle's beat, so the
  // output line can be captured on the same edge the last beat lands.
  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_slot
    logic [BEAT_W-1:0] slot_q;
    assign beat_onehot[gi] = beat_hit && (32'(grant_beat_i) == gi);
    always_ff @(posedge clk_i) begin
      if (!rstn_i)              slot_q <= '0;
      else if (beat_onehot[gi]) slot_q <= grant_data_i;
    end
    assign merged[gi*BEAT_W +: BEAT_W] = beat_onehot[gi] ? grant_data_i : slot_q;
  end

  assign mask_upd = mask_q | beat_onehot;
  assign full     = &mask_upd;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    line_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_valid_i) begin
          addr_d  = miss_paddr_i;
          mask_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = kill_i ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d  = cnt_q + 1'b1;
        mask_d = mask_upd;
        if (timeout_hit) begin
          mask_d  = '0;
          state_d = ST_IDLE;
        end else if (kill_i) begin
          if (full) begin
            mask_d  = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (full) begin
          mask_d    = '0;
          line_load = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DRAIN: begin
        cnt_d  = cnt_q + 1'b1;
        mask_d = mask_upd;
        if (timeout_hit || full) begin
          mask_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      line_paddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      if (line_load) begin
        line_q       <= merged;
        line_paddr_q <= addr_q;
      end
    end
  end

  // Outputs are forced quiet while reset is held, not only after its edge.
  assign miss_ready_o         = rstn_i && (state_q == ST_IDLE);
  assign acquire_valid_o      = rstn_i && (state_q == ST_REQ);
  assign line_valid_o         = rstn_i && (state_q == ST_DONE);
  assign timeout_o            = rstn_i && timeout_hit;
  assign acquire_addr_block_o = rstn_i ? addr_q : '0;
  assign line_paddr_o         = rstn_i ? line_paddr_q : '0;
  assign line_data_o          = rstn_i ? line_q : '0;

endmodule

// File: tb/tb_icache_refill_requester.sv
// Randomized plus directed bench for icache_refill_requester, checked every
// cycle against a transaction-level model of a single outstanding refill.
module tb_icache_refill_requester;

  localparam int NB = 4;
  localparam int TO = 16;
  localparam int LW = 128 * NB;

  localparam logic [127:0] DA = {32{4'hA}};
  localparam logic [127:0] DB = {32{4'hB}};
  localparam logic [127:0] DC = {32{4'hC}};
  localparam logic [127:0] DD = {32{4'hD}};

  logic          clk = 1'b0;
  logic          rstn, miss_valid, kill, grant_valid;
  logic [25:0]   miss_paddr;
  logic [127:0]  grant_data;
  logic [1:0]    grant_beat;
  logic          miss_ready, acq_valid, line_valid, timeout;
  logic [25:0]   acq_addr, line_paddr;
  logic [LW-1:0] line_data;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: one refill in flight, described by plain flags
  bit            m_acq_due, m_out, m_abandoned, m_deliver;
  int            m_age;
  bit            m_have [NB];
  logic [127:0]  m_beats [NB];
  logic [25:0]   m_addr, m_paddr;
  logic [LW-1:0] m_line;

  // observations of the most recent cycle
  logic          o_ready, o_acq, o_lv, o_to;
  logic [25:0]   o_aaddr, o_lpaddr;
  logic [LW-1:0] o_ldata, o_last_line;
  int            line_cnt, to_cnt;

  icache_refill_requester #(.NUM_BEATS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .miss_valid_i(miss_valid), .miss_paddr_i(miss_paddr), .miss_ready_o(miss_ready),
    .kill_i(kill),
    .acquire_valid_o(acq_valid), .acquire_addr_block_o(acq_addr),
    .grant_valid_i(grant_valid), .grant_data_i(grant_data), .grant_beat_i(grant_beat),
    .line_valid_o(line_valid), .line_data_o(line_data), .line_paddr_o(line_paddr),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic mv, input logic [25:0] ma,
                              input logic k, input logic gv, input logic [1:0] gb,
                              input logic [127:0] gd);
    bit all;
    if (!r) begin
      m_acq_due = 0; m_out = 0; m_deliver = 0; m_abandoned = 0; m_age = 0;
      for (int i = 0; i < NB; i++) m_have[i] = 0;
      m_addr = '0; m_paddr = '0; m_line = '0;
    end else if (m_deliver) begin
      m_deliver = 0;
    end else if (m_acq_due) begin
      m_acq_due = 0; m_out = 1; m_age = 0; m_abandoned = k;
      for (int i = 0; i < NB; i++) m_have[i] = 0;
    end else if (m_out) begin
      if (gv) begin
        m_beats[gb] = gd;
        m_have[gb]  = 1;
      end
      all = 1;
      for (int i = 0; i < NB; i++) if (!m_have[i]) all = 0;
      if (m_age == TO - 1) begin
        m_out = 0;
        for (int i = 0; i < NB; i++) m_have[i] = 0;
      end else if (all) begin
        m_out = 0;
        for (int i = 0; i < NB; i++) m_have[i] = 0;
        if (!m_abandoned && !k) begin
          m_deliver = 1;
          for (int i = 0; i < NB; i++) m_line[i*128 +: 128] = m_beats[i];
          m_paddr = m_addr;
        end
      end else begin
        if (k) m_abandoned = 1;
        m_age++;
      end
    end else if (mv) begin
      m_addr    = ma;
      m_acq_due = 1;
    end
  endtask

  // one clock: drive at negedge, compare 1ns later, advance model at posedge
  task automatic step(input logic r, input logic mv, input logic [25:0] ma,
                      input logic k, input logic gv, input logic [1:0] gb,
                      input logic [127:0] gd);
    logic e_ready;
    @(negedge clk);
    rstn = r; miss_valid = mv; miss_paddr = ma; kill = k;
    grant_valid = gv; grant_beat = gb; grant_data = gd;
    #1;
    o_ready = miss_ready; o_acq = acq_valid; o_lv = line_valid; o_to = timeout;
    o_aaddr = acq_addr; o_lpaddr = line_paddr; o_ldata = line_data;
    if (o_lv === 1'b1) begin line_cnt++; o_last_line = o_ldata; end
    if (o_to === 1'b1) to_cnt++;
    e_ready = r && !m_out && !m_acq_due && !m_deliver;
    chk("miss_ready",    LW'(o_ready),  LW'(e_ready));
    chk("acquire_valid", LW'(o_acq),    LW'(r && m_acq_due));
    chk("acquire_addr",  LW'(o_aaddr),  LW'(r ? m_addr : 26'd0));
    chk("line_valid",    LW'(o_lv),     LW'(r && m_deliver));
    chk("line_paddr",    LW'(o_lpaddr), LW'(r ? m_paddr : 26'd0));
    chk("line_data",     o_ldata,       r ? m_line : '0);
    chk("timeout",       LW'(o_to),     LW'(r && m_out && (m_age == TO - 1)));
    @(posedge clk);
    model_update(r, mv, ma, k, gv, gb, gd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic beat(input logic [1:0] b, input logic [127:0] d);
    step(1, 0, '0, 0, 1, b, d);
  endtask

  task automatic start_miss(input logic [25:0] a);
    step(1, 1, a, 0, 0, '0, '0);
    step(1, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    logic ready_seen;
    int   pulse_at;
    rstn = 0; miss_valid = 0; miss_paddr = '0; kill = 0;
    grant_valid = 0; grant_beat = '0; grant_data = '0;
    line_cnt = 0; to_cnt = 0; o_last_line = '0;

    // reset, then in-order line
    repeat (3) step(0, 1, 26'h3FF, 1, 1, 2'd1, DA);
    chk("rst_ready_low", LW'(o_ready), LW'(1'b0));
    chk("rst_line_zero", o_ldata, '0);
    idle(1);
    chk("ready_after_rst", LW'(o_ready), LW'(1'b1));
    step(1, 1, 26'h0000010, 0, 0, '0, '0);
    step(1, 0, '0, 0, 0, '0, '0);
    chk("s1_acq_pulse", LW'(o_acq), LW'(1'b1));
    chk("s1_acq_addr", LW'(o_aaddr), LW'(26'h0000010));
    beat(0, DA); beat(1, DB); beat(2, DC); beat(3, DD);
    chk("s1_no_early_line", LW'(o_lv), LW'(1'b0));
    line_cnt = 0;
    idle(1);
    chk("s1_line_pulse", LW'(o_lv), LW'(1'b1));
    chk("s1_line_data", o_ldata, {DD, DC, DB, DA});
    chk("s1_line_paddr", LW'(o_lpaddr), LW'(26'h0000010));
    idle(1);
    chk("s1_back_idle", LW'(o_ready), LW'(1'b1));
    chk("s1_data_held", o_ldata, {DD, DC, DB, DA});

    // out-of-order beats
    line_cnt = 0;
    start_miss(26'h00002A5);
    beat(3, {4{32'h3333_0003}}); beat(1, {4{32'h1111_0001}});
    beat(0, {4{32'h0000_0010}}); beat(2, {4{32'h2222_0002}});
    idle(3);
    chk("s2_line_count", LW'(line_cnt), LW'(1));
    chk("s2_slots", o_last_line, {{4{32'h3333_0003}}, {4{32'h2222_0002}},
                                  {4{32'h1111_0001}}, {4{32'h0000_0010}}});

    // kill after beat 1: drain to the last beat, no line
    line_cnt = 0;
    start_miss(26'h0001234);
    beat(0, DA); beat(1, DB);
    step(1, 0, '0, 1, 0, '0, '0);
    ready_seen = o_ready;
    beat(2, DC);
    ready_seen = ready_seen | o_ready;
    beat(3, DD);
    ready_seen = ready_seen | o_ready;
    chk("s3_ready_held_low", LW'(ready_seen), LW'(1'b0));
    idle(1);
    chk("s3_ready_after_drain", LW'(o_ready), LW'(1'b1));
    chk("s3_no_line", LW'(line_cnt), LW'(0));

    // timeout with no grants
    to_cnt = 0; pulse_at = -1;
    start_miss(26'h0000ABC);
    chk("s4_acq_pulse", LW'(o_acq), LW'(1'b1));
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      if (o_to === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("s4_timeout_cycle", LW'(pulse_at), LW'(16));
    chk("s4_timeout_once", LW'(to_cnt), LW'(1));
    idle(1);
    chk("s4_idle_after", LW'(o_ready), LW'(1'b1));

    // duplicate beat 2: last data wins, one line
    line_cnt = 0;
    start_miss(26'h0000777);
    beat(2, {4{32'hDEAD_0002}}); beat(0, DA);
    beat(2, {4{32'hBEEF_0002}}); beat(1, DB); beat(3, DD);
    idle(3);
    chk("s5_line_count", LW'(line_cnt), LW'(1));
    chk("s5_line_data", o_last_line, {DD, {4{32'hBEEF_0002}}, DB, DA});

    // reset mid-refill
    line_cnt = 0; to_cnt = 0;
    start_miss(26'h0000555);
    beat(0, DA); beat(1, DB); beat(2, DC);
    step(0, 0, '0, 0, 1, 2'd3, DD);
    chk("s6_rst_outputs", LW'({o_ready, o_acq, o_lv, o_to}), LW'(4'b0000));
    chk("s6_rst_data", o_ldata, '0);
    chk("s6_rst_addrs", LW'({o_aaddr, o_lpaddr}), LW'(52'd0));
    step(0, 0, '0, 0, 0, '0, '0);
    idle(1);
    chk("s6_ready_after_rst", LW'(o_ready), LW'(1'b1));
    idle(20);
    chk("s6_no_line_or_timeout", LW'({line_cnt, to_cnt}), LW'(64'd0));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, gv;
      r  = ($urandom_range(0, 299) != 0);
      gv = m_out ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      step(r, $urandom_range(0, 1) == 1, 26'($urandom), $urandom_range(0, 19) == 0,
           gv, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
